// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, address widths and X/Y coordinate
// packing helpers for the 8-bit destination field.
package noc_pkg;

    localparam int FLIT_W  = 16;
    localparam int ADDR_W  = 8;
    localparam int COORD_W = ADDR_W / 2;

    // Flit as seen on the router ports; the router routes on dest.
    typedef struct packed {
        logic [7:0] payload;
        logic [7:0] dest;
    } flit_t;

    // Build a destination address: X in the upper nibble, Y in the lower.
    function automatic logic [ADDR_W-1:0] pack_coord(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y
    );
        return {x, y};
    endfunction

    // Extract the X coordinate from a packed destination address.
    function automatic logic [COORD_W-1:0] coord_x(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:COORD_W];
    endfunction

    // Extract the Y coordinate from a packed destination address.
    function automatic logic [COORD_W-1:0] coord_y(input logic [ADDR_W-1:0] addr);
        return addr[COORD_W-1:0];
    endfunction

endpackage

// File: rtl/ni_rx_fifo.sv
// Synchronous FIFO buffering flits ejected from the router. A push while
// full is dropped unless a pop frees the slot in the same cycle.
module ni_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_push_data,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_full,
    output logic         o_empty,
    output logic         o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push_eff;
    logic          w_pop_eff;

    assign o_full     = (r_count == CNT_MAX);
    assign o_empty    = (r_count == {CW{1'b0}});
    assign w_pop_eff  = i_pop & ~o_empty;
    assign w_push_eff = i_push & (~o_full | w_pop_eff);
    assign o_overflow = i_push & o_full & ~w_pop_eff;
    assign o_head     = r_mem[r_rd_ptr];

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (w_push_eff) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push_eff) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop_eff) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count <= r_count + CW'(w_push_eff) - CW'(w_pop_eff);
        end
    end

endmodule

// File: rtl/local_net_iface.sv
// Network interface between a core and a router's local port.
// TX: packs {payload, dest} flits and injects them under credit flow control.
// RX: buffers ejected flits and returns one credit per flit consumed.
// Optional feature macro: LOCAL_NI_ERRCHK_EN adds the sticky err_o output.
module local_net_iface
    import noc_pkg::*;
#(
    parameter int CREDITS  = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        core_tx_payload,
    input  logic [7:0]        core_tx_dest,
    input  logic              core_tx_valid,
    output logic              core_tx_ready,
    output logic [FLIT_W-1:0] core_rx_data,
    output logic              core_rx_valid,
    input  logic              core_rx_ready,
    output logic [FLIT_W-1:0] noc_data_o,
    output logic              noc_valid_o,
    input  logic              noc_credit_i,
    input  logic [FLIT_W-1:0] noc_data_i,
    input  logic              noc_valid_i,
    output logic              noc_credit_o
`ifdef LOCAL_NI_ERRCHK_EN
    ,
    output logic              err_o
`endif
);

    localparam logic [3:0] CRED_MAX = 4'(CREDITS);

    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_next;
    logic              r_tx_ready;
    logic [FLIT_W-1:0] r_noc_data;
    logic              r_noc_valid;
    logic              r_credit_o;
    logic              w_accept;
    logic              w_pop;
    logic              w_rx_empty;
    logic              w_rx_full;
    logic              w_rx_ovf;
    flit_t             w_tx_flit;

    assign w_accept  = core_tx_valid & r_tx_ready;
    assign w_tx_flit = '{payload: core_tx_payload, dest: core_tx_dest};

    // Credit counter next value; a credit at full count saturates.
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_accept && !noc_credit_i) begin
            w_cnt_next = r_cnt - 4'd1;
        end else if (!w_accept && noc_credit_i) begin
            if (r_cnt == CRED_MAX) begin
                w_cnt_next = r_cnt;
            end else begin
                w_cnt_next = r_cnt + 4'd1;
            end
        end else begin
            w_cnt_next = r_cnt;
        end
    end

    // TX state: credit count, registered ready, and the one-cycle flit launch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= CRED_MAX;
            r_tx_ready  <= 1'b0;
            r_noc_data  <= {FLIT_W{1'b0}};
            r_noc_valid <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_next;
            r_tx_ready  <= (w_cnt_next != 4'd0);
            r_noc_valid <= w_accept;
            if (w_accept) begin
                r_noc_data <= w_tx_flit;
            end
        end
    end

    assign w_pop = ~w_rx_empty & core_rx_ready;

    ni_rx_fifo #(
        .DEPTH (RX_DEPTH),
        .W     (FLIT_W)
    ) u_rx_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (noc_valid_i),
        .i_push_data (noc_data_i),
        .i_pop       (w_pop),
        .o_head      (core_rx_data),
        .o_full      (w_rx_full),
        .o_empty     (w_rx_empty),
        .o_overflow  (w_rx_ovf)
    );

    // Return one credit to the router the cycle after each pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credit_o <= 1'b0;
        end else begin
            r_credit_o <= w_pop;
        end
    end

`ifdef LOCAL_NI_ERRCHK_EN
    logic w_tx_ovf;
    logic r_err;
    logic w_unused_rx;

    assign w_tx_ovf    = noc_credit_i & ~w_accept & (r_cnt == CRED_MAX);
    assign w_unused_rx = w_rx_full;

    // Sticky protocol error: credit overflow or dropped RX flit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= r_err | w_tx_ovf | w_rx_ovf;
        end
    end

    assign err_o = r_err;
`else
    logic w_unused_rx;
    assign w_unused_rx = w_rx_full ^ w_rx_ovf;
`endif

    assign core_tx_ready = r_tx_ready;
    assign core_rx_valid = ~w_rx_empty;
    assign noc_data_o    = r_noc_data;
    assign noc_valid_o   = r_noc_valid;
    assign noc_credit_o  = r_credit_o;

endmodule

// File: tb/tb_local_net_iface.sv
// Directed, table-driven bench for local_net_iface (CREDITS=4, RX_DEPTH=4).
module tb_local_net_iface;

    logic        clk;
    logic        rst;
    logic [7:0]  core_tx_payload;
    logic [7:0]  core_tx_dest;
    logic        core_tx_valid;
    logic        core_tx_ready;
    logic [15:0] core_rx_data;
    logic        core_rx_valid;
    logic        core_rx_ready;
    logic [15:0] noc_data_o;
    logic        noc_valid_o;
    logic        noc_credit_i;
    logic [15:0] noc_data_i;
    logic        noc_valid_i;
    logic        noc_credit_o;
`ifdef LOCAL_NI_ERRCHK_EN
    logic        err_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        txv;
        logic [7:0]  pay;
        logic [7:0]  dst;
        logic        cr;
        logic        nvi;
        logic [15:0] nd;
        logic        rxr;
        logic        e_rdy;
        logic        e_nv;
        logic [15:0] e_nd;
        logic        e_rxv;
        logic [15:0] e_rxd;
        logic        e_cro;
        logic        e_err;
    } vec_t;

    vec_t tx_tab [20];
    vec_t rx_tab [12];

    local_net_iface #(.CREDITS(4), .RX_DEPTH(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .core_tx_payload (core_tx_payload),
        .core_tx_dest    (core_tx_dest),
        .core_tx_valid   (core_tx_valid),
        .core_tx_ready   (core_tx_ready),
        .core_rx_data    (core_rx_data),
        .core_rx_valid   (core_rx_valid),
        .core_rx_ready   (core_rx_ready),
        .noc_data_o      (noc_data_o),
        .noc_valid_o     (noc_valid_o),
        .noc_credit_i    (noc_credit_i),
        .noc_data_i      (noc_data_i),
        .noc_valid_i     (noc_valid_i),
        .noc_credit_o    (noc_credit_o)
`ifdef LOCAL_NI_ERRCHK_EN
        ,
        .err_o           (err_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic txv, input logic [7:0] pay, input logic [7:0] dst, input logic cr,
        input logic nvi, input logic [15:0] nd, input logic rxr,
        input logic e_rdy, input logic e_nv, input logic [15:0] e_nd,
        input logic e_rxv, input logic [15:0] e_rxd, input logic e_cro, input logic e_err
    );
        vec_t v;
        v.txv = txv; v.pay = pay; v.dst = dst; v.cr = cr;
        v.nvi = nvi; v.nd = nd; v.rxr = rxr;
        v.e_rdy = e_rdy; v.e_nv = e_nv; v.e_nd = e_nd;
        v.e_rxv = e_rxv; v.e_rxd = e_rxd; v.e_cro = e_cro; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic txv, input logic [7:0] pay, input logic [7:0] dst,
                         input logic cr, input logic nvi, input logic [15:0] nd, input logic rxr);
        core_tx_valid   = txv;
        core_tx_payload = pay;
        core_tx_dest    = dst;
        noc_credit_i    = cr;
        noc_valid_i     = nvi;
        noc_data_i      = nd;
        core_rx_ready   = rxr;
    endtask

    task automatic apply(input vec_t v, input string tag, input int idx);
        drive(v.txv, v.pay, v.dst, v.cr, v.nvi, v.nd, v.rxr);
        step();
        chk({tag, "_ready"}, idx, 16'(core_tx_ready), 16'(v.e_rdy));
        chk({tag, "_noc_valid"}, idx, 16'(noc_valid_o), 16'(v.e_nv));
        chk({tag, "_noc_data"}, idx, noc_data_o, v.e_nd);
        chk({tag, "_rx_valid"}, idx, 16'(core_rx_valid), 16'(v.e_rxv));
        if (v.e_rxv) begin
            chk({tag, "_rx_data"}, idx, core_rx_data, v.e_rxd);
        end
        chk({tag, "_credit_o"}, idx, 16'(noc_credit_o), 16'(v.e_cro));
`ifdef LOCAL_NI_ERRCHK_EN
        chk({tag, "_err"}, idx, 16'(err_o), 16'(v.e_err));
`endif
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 0, 16'(core_tx_ready), 16'h0);
        chk({tag, "_noc_valid"}, 0, 16'(noc_valid_o), 16'h0);
        chk({tag, "_noc_data"}, 0, noc_data_o, 16'h0);
        chk({tag, "_rx_valid"}, 0, 16'(core_rx_valid), 16'h0);
        chk({tag, "_credit_o"}, 0, 16'(noc_credit_o), 16'h0);
`ifdef LOCAL_NI_ERRCHK_EN
        chk({tag, "_err"}, 0, 16'(err_o), 16'h0);
`endif
    endtask

    initial begin
        // TX: four accepts exhaust credits, credit returns, accept+credit at cnt=1, saturation.
        //             txv  pay    dst    cr    nvi   nd     rxr   rdy   nv    nd         rxv   rxd    cro   err
        tx_tab[0]  = mk(1'b1, 8'hA5, 8'h12, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 16'hA512, 1'b0, 16'h0, 1'b0, 1'b0);
        tx_tab[1]  = mk(1'b1, 8'h01, 8'h02, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h0102, 1'b0, 16'h0, 1'b0, 1'b0);
        tx_tab[2]  = mk(1'b1, 8'h03, 8'h04, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h0304, 1'b0, 16'h0, 1'b0, 1'b0);
        tx_tab[3]  = mk(1'b1, 8'h05, 8'h06, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0506, 1'b0, 16'h0, 1'b0, 1'b0);
        tx_tab[4]  = mk(1'b1, 8'h07, 8'h08, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0506, 1'b0, 16'h0, 1'b0, 1'b0);
        tx_tab[5]  = mk(1'b1, 8'h07, 8'h08, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0506, 1'b0, 16'h0, 1'b0, 1'b0);
        tx_tab[6]  = mk(1'b1, 8'h07, 8'h08, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0708, 1'b0, 16'h0, 1'b0, 1'b0);
        tx_tab[7]  = mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0708, 1'b0, 16'h0, 1'b0, 1'b0);
        tx_tab[8]  = mk(1'b1, 8'h09, 8'h0A, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h090A, 1'b0, 16'h0, 1'b0, 1'b0);
        tx_tab[9]  = mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h090A, 1'b0, 16'h0, 1'b0, 1'b0);
        tx_tab[10] = mk(1'b1, 8'h0B, 8'h0C, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0B0C, 1'b0, 16'h0, 1'b0, 1'b0);
        tx_tab[11] = mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0B0C, 1'b0, 16'h0, 1'b0, 1'b0);
        tx_tab[12] = mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0B0C, 1'b0, 16'h0, 1'b0, 1'b0);
        tx_tab[13] = mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0B0C, 1'b0, 16'h0, 1'b0, 1'b0);
        tx_tab[14] = mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0B0C, 1'b0, 16'h0, 1'b0, 1'b0);
        tx_tab[15] = mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0B0C, 1'b0, 16'h0, 1'b0, 1'b1);
        tx_tab[16] = mk(1'b1, 8'h10, 8'h20, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h1020, 1'b0, 16'h0, 1'b0, 1'b1);
        tx_tab[17] = mk(1'b1, 8'h11, 8'h21, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h1121, 1'b0, 16'h0, 1'b0, 1'b1);
        tx_tab[18] = mk(1'b1, 8'h12, 8'h22, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h1222, 1'b0, 16'h0, 1'b0, 1'b1);
        tx_tab[19] = mk(1'b1, 8'h13, 8'h23, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h1323, 1'b0, 16'h0, 1'b0, 1'b1);

        // RX: fill to full, push+pop while full, drop on full, drain in order with credit pulses.
        rx_tab[0]  = mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 16'h0101, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0101, 1'b0, 1'b0);
        rx_tab[1]  = mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 16'h0202, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0101, 1'b0, 1'b0);
        rx_tab[2]  = mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 16'h0303, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0101, 1'b0, 1'b0);
        rx_tab[3]  = mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 16'h0404, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0101, 1'b0, 1'b0);
        rx_tab[4]  = mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 16'h0505, 1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0202, 1'b1, 1'b0);
        rx_tab[5]  = mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 16'h0606, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0202, 1'b0, 1'b1);
        rx_tab[6]  = mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0,    1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0303, 1'b1, 1'b1);
        rx_tab[7]  = mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0,    1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0404, 1'b1, 1'b1);
        rx_tab[8]  = mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0,    1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0404, 1'b0, 1'b1);
        rx_tab[9]  = mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0,    1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0505, 1'b1, 1'b1);
        rx_tab[10] = mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0,    1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0,    1'b1, 1'b1);
        rx_tab[11] = mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0,    1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0,    1'b0, 1'b1);

        // Reset and release: ready rises one edge after deassert.
        rst = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0, 1'b0);
        step();
        step();
        chk_reset_outputs("rst");
        rst = 1'b0;
        #1;
        chk("rel_ready_pre", 0, 16'(core_tx_ready), 16'h0);
        step();
        chk("rel_ready_post", 0, 16'(core_tx_ready), 16'h1);
        chk("rel_noc_valid", 0, 16'(noc_valid_o), 16'h0);
        chk("rel_credit_o", 0, 16'(noc_credit_o), 16'h0);

        for (int i = 0; i < 20; i++) begin
            apply(tx_tab[i], "tx", i);
        end

        // Clear the sticky error and credit state before the RX phase.
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0, 1'b0);
        rst = 1'b1;
        #2;
        chk_reset_outputs("rst2");
        rst = 1'b0;
        step();
        chk("rst2_ready_post", 0, 16'(core_tx_ready), 16'h1);

        for (int i = 0; i < 12; i++) begin
            apply(rx_tab[i], "rx", i);
        end

        // Mid-operation reset: 2 flits buffered, cnt=1, credit pulse pending.
        drive(1'b1, 8'hC1, 8'h01, 1'b0, 1'b1, 16'h0A0A, 1'b0);
        step();
        drive(1'b1, 8'hC2, 8'h02, 1'b0, 1'b1, 16'h0B0B, 1'b0);
        step();
        drive(1'b1, 8'hC3, 8'h03, 1'b0, 1'b1, 16'h0C0C, 1'b0);
        step();
        chk("mid_ready_cnt1", 0, 16'(core_tx_ready), 16'h1);
        chk("mid_noc_data", 0, noc_data_o, 16'hC303);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0, 1'b1);
        step();
        chk("mid_credit_pending", 0, 16'(noc_credit_o), 16'h1);
        chk("mid_head", 0, core_rx_data, 16'h0B0B);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0, 1'b0);
        rst = 1'b1;
        #2;
        chk_reset_outputs("mid_rst");
        rst = 1'b0;
        step();
        chk("mid_ready_post", 0, 16'(core_tx_ready), 16'h1);
        chk("mid_rx_valid_post", 0, 16'(core_rx_valid), 16'h0);
        chk("mid_credit_post", 0, 16'(noc_credit_o), 16'h0);

        // Credits restored to 4: exactly four accepts before ready drops.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'hD0 + i), 8'(8'h30 + i), 1'b0, 1'b0, 16'h0, 1'b0);
            step();
            chk("mid_cnt_ready", i, 16'(core_tx_ready), (i < 3) ? 16'h1 : 16'h0);
            chk("mid_cnt_data", i, noc_data_o, {8'(8'hD0 + i), 8'(8'h30 + i)});
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0, 1'b0);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
